// File: rtl/lbuf_scanout_pkg.sv
// Shared video definitions for the sprite line-buffer path: scanout FSM states,
// the transparent value and line-buffer geometry.
package lbuf_scanout_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_CAP  = 2'd2,
    ST_CLR  = 2'd3
  } scan_state_e;

  // Also used by the sprite renderer as its transparency test value.
  localparam logic [7:0] CLRVAL_DEF = 8'h00;

  localparam int HW_DEF = 9;
  localparam int LB_AW  = HW_DEF + 1;

endpackage

// File: rtl/lbuf_scanout.sv
// Sprite line-buffer scanout: per pixel, read the displayed bank, present the
// pixel to the mixer, then write the transparent value back to the same slot.
module lbuf_scanout
  import lbuf_scanout_pkg::*;
#(
  parameter logic [7:0] CLRVAL = CLRVAL_DEF,
  parameter int         HW     = HW_DEF
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          PCE,
  input  logic [HW-1:0] HPOS,
  input  logic          VPOS0,
  input  logic          HBLK,
  output logic [HW:0]   LB_AD,
  output logic          LB_WR,
  output logic [7:0]    LB_DI,
  input  logic [7:0]    LB_DO,
  output logic [7:0]    PIX,
  output logic          PIXV,
  output logic          OVR
);

  scan_state_e state_q, state_d;
  logic [HW:0] ad_q, ad_d;
  logic        wr_q, wr_d;
  logic [7:0]  pix_q, pix_d;
  logic        pixv_q, pixv_d;
  logic        ovr_q, ovr_d;

  // Next-state and output-register decode for the read/capture/clear sequence.
  always_comb begin
    state_d = state_q;
    ad_d    = ad_q;
    wr_d    = 1'b0;
    pix_d   = pix_q;
    pixv_d  = pixv_q;
    ovr_d   = ovr_q;

    case (state_q)
      ST_IDLE: begin
        if (PCE) begin
          if (HBLK) begin
            pix_d  = CLRVAL;
            pixv_d = 1'b0;
          end else begin
            ad_d    = {VPOS0, HPOS};
            state_d = ST_RD;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RD: begin
        state_d = ST_CAP;
      end
      ST_CAP: begin
        // RAM output now holds the addressed pixel; the clear reuses the held address.
        pix_d   = LB_DO;
        pixv_d  = (LB_DO != CLRVAL);
        wr_d    = 1'b1;
        state_d = ST_CLR;
      end
      ST_CLR: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (PCE && (state_q != ST_IDLE)) begin
      ovr_d = 1'b1;
    end else begin
      ovr_d = ovr_d;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      ad_q    <= '0;
      wr_q    <= 1'b0;
      pix_q   <= CLRVAL;
      pixv_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ad_q    <= ad_d;
      wr_q    <= wr_d;
      pix_q   <= pix_d;
      pixv_q  <= pixv_d;
      ovr_q   <= ovr_d;
    end
  end

  assign LB_AD = ad_q;
  assign LB_WR = wr_q;
  assign LB_DI = CLRVAL;
  assign PIX   = pix_q;
  assign PIXV  = pixv_q;
  assign OVR   = ovr_q;

endmodule
